leve1_id: RTL and testbench
===========================

Name: leve1_id

Overview:
- Decode/operand-fetch stage directly upstream of the execute stage. It owns the 31×XLEN integer register file and the machine CSR file.
- It captures the instruction handed over by fetch, reads rs1/rs2/CSR operands with forwarding from the execute and writeback positions, and registers them into the execute stage's inputs.
- It performs GPR and CSR writeback from the execute stage's WB_* outputs and drops the captured instruction on a redirect flush.

Parameters:
- XLEN, 64, data width; taken from the `XLEN define.
- NOP_INSTR, 32'h0000_0013, instruction word driven on OINSTR at reset.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- IF_VALID  in  1  fetch offers an instruction.
- IF_READY  out  1  stage accepts an instruction.
- IF_PC  in  XLEN  PC of the offered instruction.
- IF_INSTR  in  32  offered instruction word.
- FLASH  in  1  redirect from execute (its OFLASH); kills the instruction being captured.
- EX_VALID  in  1  execute stage holds a valid instruction (its IVALID, which is this block's OVALID).
- EX_WE  in  1  execute's combinational GPR write enable for that instruction.
- FWD_RD  in  XLEN  execute's combinational rd result.
- FWD_CSRD  in  XLEN  execute's combinational CSR operand.
- WB_VALID  in  1  writeback slot valid (execute OVALID).
- WB_INSTR  in  32  writeback instruction (execute OINSTR).
- WB_WE  in  1  GPR write enable.
- WB_RD  in  XLEN  GPR write data.
- WB_CSRD  in  XLEN  CSR operand.
- OVALID  out  1  to execute IVALID.
- OPC  out  XLEN  to execute IPC.
- OINSTR  out  32  to execute IINSTR.
- ORS1  out  XLEN  to execute IRS1.
- ORS2  out  XLEN  to execute IRS2.
- OCSR  out  XLEN  to execute ICSR.

Behaviour:

Reset (asynchronous, RSTn low):
- OVALID=0, OPC=0, OINSTR=NOP_INSTR, ORS1=ORS2=OCSR=0.
- All GPRs and CSRs cleared to 0.
- Reset mid-operation discards the in-flight instruction and any pending write.

Handshake:
- IF_READY = RSTn; execute never stalls.
- Capture occurs on every edge where IF_VALID && IF_READY.
- Next OVALID = IF_VALID && IF_READY && !FLASH.
- OPC/OINSTR/operands load only on capture and hold otherwise.
- A flushed instruction leaves OVALID=0; OPC/OINSTR may still update but are don't-care.
- Latency: one cycle from fetch handover to execute input.

Operand read (combinational, registered at capture):
- Fields: rs1=IF_INSTR[19:15], rs2=[24:20], csr=[31:20].
- GPR priority per source:
  - x0 always reads 0 and is never forwarded.
  - Else, if EX_VALID && EX_WE && OINSTR[11:7]==rs, use FWD_RD.
  - Else, if WB_VALID && WB_WE && WB_INSTR[11:7]==rs, use WB_RD.
  - Else, use the GPR file.

CSR file and write semantics:
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343. Other addresses read 0 and ignore writes.
- CSR write instruction: opcode 1110011 with funct3≠000, or MRET (word 0x30200073).
- MRET targets mstatus and writes the value verbatim.
- CSRRW/CSRRWI: new = operand.
- CSRRS/CSRRSI: new = old|operand; no write when the rs1/uimm field is 0.
- CSRRC/CSRRCI: new = old&~operand; no write when the rs1/uimm field is 0.

CSR forwarding (priority):
- 1. EX_VALID, execute instruction writes the same CSR: new value computed with old=OCSR and operand=FWD_CSRD.
- 2. WB_VALID, writeback instruction writes the same CSR: new value computed with old=file value and operand=WB_CSRD.
- 3. CSR file.
- Capture of an MRET reads mstatus into OCSR.

Writeback (every edge):
- GPR[WB_INSTR[11:7]] <= WB_RD when WB_VALID && WB_WE && rd≠0.
- CSR written with the computed new value when WB_VALID and the instruction is a CSR write.
- Writeback is independent of FLASH and capture.

Boundary conditions:
- EX and WB forwarding hits on the same register resolve to EX (youngest).
- Same-cycle write and read of the same register is covered by WB forwarding; no read-before-write hazard.
- Back-to-back flushes produce consecutive OVALID=0 cycles.

Test Plan:
- Reset → OVALID=0, OINSTR=0x00000013; every GPR read returns 0 after release.
- Back-to-back dependent instructions: addi x5,x0,7 followed by addi x6,x5,1 → ORS1=7 taken from FWD_RD. A third instruction reading x5 gets 7 from WB_RD, and the fourth gets 7 from the GPR file.
- Write to x0, then read x0 → ORS1=0 from every source (file, EX forward, WB forward).
- csrrw x1,mscratch,x2 (x2=0xA5) followed by csrrs x3,mscratch,x4 (x4=0x5A) → second OCSR=0xA5. After writeback, mscratch=0xFF.
- FLASH asserted on the capture edge → OVALID=0 the next cycle while the concurrent writeback still updates its GPR. The next unflushed capture gives OVALID=1.
- RSTn pulsed low mid-stream with an execute write pending → outputs return to reset values immediately and the pending register stays 0.

Source files
------------

// File: rtl/leve1_id.sv
// ============================================================================
//  Module   : leve1_id
//  Purpose  : Decode/operand-fetch stage. Owns the GPR and machine CSR files,
//             forwards from execute/writeback and registers execute inputs.
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 64
`endif
`default_nettype none

module leve1_id #(
  parameter int          XLEN      = `XLEN,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            IF_VALID,
  output logic            IF_READY,
  input  logic [XLEN-1:0] IF_PC,
  input  logic [31:0]     IF_INSTR,
  input  logic            FLASH,
  input  logic            EX_VALID,
  input  logic            EX_WE,
  input  logic [XLEN-1:0] FWD_RD,
  input  logic [XLEN-1:0] FWD_CSRD,
  input  logic            WB_VALID,
  input  logic [31:0]     WB_INSTR,
  input  logic            WB_WE,
  input  logic [XLEN-1:0] WB_RD,
  input  logic [XLEN-1:0] WB_CSRD,
  output logic            OVALID,
  output logic [XLEN-1:0] OPC,
  output logic [31:0]     OINSTR,
  output logic [XLEN-1:0] ORS1,
  output logic [XLEN-1:0] ORS2,
  output logic [XLEN-1:0] OCSR
);

  localparam logic [31:0] c_MRET      = 32'h3020_0073;
  localparam logic [6:0]  c_OP_SYSTEM = 7'b1110011;
  localparam logic [11:0] c_MSTATUS   = 12'h300;
  localparam logic [2:0]  c_NO_CSR    = 3'd7;

  logic [XLEN-1:0] r_gpr [1:31];
  logic [XLEN-1:0] r_csr [0:5];

  logic            w_capture;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [11:0]     w_csr_addr;
  logic [2:0]      w_csr_idx;
  logic [XLEN-1:0] w_csr_val;
  logic            w_ex_csr_hit;
  logic [11:0]     w_wb_csr_addr;
  logic [2:0]      w_wb_csr_idx;
  logic [XLEN-1:0] w_wb_csr_old;
  logic            w_wb_csr_we;
  logic [XLEN-1:0] w_wb_csr_new;

  // True only when the instruction really modifies its CSR (RS/RC with a zero
  // source field leave the CSR untouched, so they must not forward either).
  function automatic logic f_csr_wr(input logic [31:0] instr);
    if (instr == c_MRET) return 1'b1;
    if (instr[6:0] != c_OP_SYSTEM || instr[14:12] == 3'b000) return 1'b0;
    case (instr[13:12])
      2'b01:   return 1'b1;
      2'b10,
      2'b11:   return instr[19:15] != 5'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] f_csr_addr(input logic [31:0] instr);
    return (instr == c_MRET) ? c_MSTATUS : instr[31:20];
  endfunction

  function automatic logic [2:0] f_csr_idx(input logic [11:0] addr);
    case (addr)
      12'h300: return 3'd0;
      12'h305: return 3'd1;
      12'h340: return 3'd2;
      12'h341: return 3'd3;
      12'h342: return 3'd4;
      12'h343: return 3'd5;
      default: return c_NO_CSR;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_csr_new(input logic [31:0] instr,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] opnd);
    if (instr == c_MRET) return opnd;
    case (instr[13:12])
      2'b01:   return opnd;
      2'b10:   return old | opnd;
      2'b11:   return old & ~opnd;
      default: return old;
    endcase
  endfunction

  assign IF_READY  = RSTn;
  assign w_capture = IF_VALID && IF_READY;
  assign w_rs1     = IF_INSTR[19:15];
  assign w_rs2     = IF_INSTR[24:20];

  // Youngest producer wins: execute, then writeback, then the file.
  always_comb begin
    w_rs1_val = '0;
    if (w_rs1 != 5'd0) begin
      if (EX_VALID && EX_WE && OINSTR[11:7] == w_rs1)            w_rs1_val = FWD_RD;
      else if (WB_VALID && WB_WE && WB_INSTR[11:7] == w_rs1)     w_rs1_val = WB_RD;
      else                                                       w_rs1_val = r_gpr[w_rs1];
    end
  end

  always_comb begin
    w_rs2_val = '0;
    if (w_rs2 != 5'd0) begin
      if (EX_VALID && EX_WE && OINSTR[11:7] == w_rs2)            w_rs2_val = FWD_RD;
      else if (WB_VALID && WB_WE && WB_INSTR[11:7] == w_rs2)     w_rs2_val = WB_RD;
      else                                                       w_rs2_val = r_gpr[w_rs2];
    end
  end

  assign w_csr_addr    = f_csr_addr(IF_INSTR);
  assign w_csr_idx     = f_csr_idx(w_csr_addr);
  assign w_wb_csr_addr = f_csr_addr(WB_INSTR);
  assign w_wb_csr_idx  = f_csr_idx(w_wb_csr_addr);
  assign w_wb_csr_old  = (w_wb_csr_idx != c_NO_CSR) ? r_csr[w_wb_csr_idx] : '0;
  assign w_wb_csr_we   = WB_VALID && f_csr_wr(WB_INSTR) && (w_wb_csr_idx != c_NO_CSR);
  assign w_wb_csr_new  = f_csr_new(WB_INSTR, w_wb_csr_old, WB_CSRD);
  assign w_ex_csr_hit  = EX_VALID && f_csr_wr(OINSTR) && (f_csr_addr(OINSTR) == w_csr_addr);

  // OCSR still holds the pre-write value of the instruction now in execute.
  always_comb begin
    w_csr_val = '0;
    if (w_csr_idx != c_NO_CSR) begin
      if (w_ex_csr_hit)                                        w_csr_val = f_csr_new(OINSTR, OCSR, FWD_CSRD);
      else if (w_wb_csr_we && w_wb_csr_addr == w_csr_addr)     w_csr_val = w_wb_csr_new;
      else                                                     w_csr_val = r_csr[w_csr_idx];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      OVALID <= 1'b0;
      OPC    <= '0;
      OINSTR <= NOP_INSTR;
      ORS1   <= '0;
      ORS2   <= '0;
      OCSR   <= '0;
      for (int i = 1; i < 32; i++) r_gpr[i] <= '0;
      for (int i = 0; i < 6; i++)  r_csr[i] <= '0;
    end else begin
      OVALID <= w_capture && !FLASH;
      if (w_capture) begin
        OPC    <= IF_PC;
        OINSTR <= IF_INSTR;
        ORS1   <= w_rs1_val;
        ORS2   <= w_rs2_val;
        OCSR   <= w_csr_val;
      end
      if (WB_VALID && WB_WE && WB_INSTR[11:7] != 5'd0)
        r_gpr[WB_INSTR[11:7]] <= WB_RD;
      if (w_wb_csr_we)
        r_csr[w_wb_csr_idx] <= w_wb_csr_new;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_leve1_id.sv
// ============================================================================
//  Module   : tb_leve1_id
//  Purpose  : Self-checking bench for leve1_id: directed vector table, reset
//             sequences and random programs against an in-order ISA model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leve1_id;

  localparam int          XLEN = 64;
  localparam logic [31:0] MRET = 32'h3020_0073;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            IF_VALID = 1'b0, IF_READY, FLASH = 1'b0;
  logic [XLEN-1:0] IF_PC = '0;
  logic [31:0]     IF_INSTR = '0;
  logic            EX_VALID = 1'b0, EX_WE = 1'b0;
  logic [XLEN-1:0] FWD_RD = '0, FWD_CSRD = '0;
  logic            WB_VALID = 1'b0, WB_WE = 1'b0;
  logic [31:0]     WB_INSTR = '0;
  logic [XLEN-1:0] WB_RD = '0, WB_CSRD = '0;
  logic            OVALID;
  logic [XLEN-1:0] OPC, ORS1, ORS2, OCSR;
  logic [31:0]     OINSTR;

  always #5 CLK = ~CLK;

  leve1_id #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RSTn(RSTn), .IF_VALID(IF_VALID), .IF_READY(IF_READY),
    .IF_PC(IF_PC), .IF_INSTR(IF_INSTR), .FLASH(FLASH),
    .EX_VALID(EX_VALID), .EX_WE(EX_WE), .FWD_RD(FWD_RD), .FWD_CSRD(FWD_CSRD),
    .WB_VALID(WB_VALID), .WB_INSTR(WB_INSTR), .WB_WE(WB_WE), .WB_RD(WB_RD),
    .WB_CSRD(WB_CSRD), .OVALID(OVALID), .OPC(OPC), .OINSTR(OINSTR),
    .ORS1(ORS1), .ORS2(ORS2), .OCSR(OCSR)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [63:0] pc, a, b, c;
  } slot_t;

  typedef struct packed {
    logic        we;
    logic [63:0] rd, csrd;
  } res_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        flash, ev;
    logic [63:0] e1, e2, ec;
  } vec_t;

  int n_cmp = 0, n_bad = 0;

  // Architectural state in program order; the stage must look exactly like this.
  logic [63:0] arch  [32];
  logic [63:0] csr_m [4096];
  slot_t       ex_s;
  logic        wb_v;
  logic [31:0] wb_i;
  res_t        wb_r;
  logic [63:0] pc_ctr = 64'h1000;
  vec_t        tbl [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    logic [31:0] i;
    i = imm;
    return {i[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] addr(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] csri(input int f3, input int rd, input int rs1, input int csr);
    return {12'(csr), 5'(rs1), 3'(f3), 5'(rd), 7'b1110011};
  endfunction

  function automatic logic impl(input logic [11:0] a);
    return a == 12'h300 || a == 12'h305 || a == 12'h340 ||
           a == 12'h341 || a == 12'h342 || a == 12'h343;
  endfunction

  function automatic logic [11:0] tgt(input logic [31:0] ins);
    return (ins == MRET) ? 12'h300 : ins[31:20];
  endfunction

  function automatic logic [63:0] gpr(input logic [4:0] i);
    return (i == 5'd0) ? 64'd0 : arch[i];
  endfunction

  function automatic logic [63:0] csrr(input logic [11:0] a);
    return impl(a) ? csr_m[a] : 64'd0;
  endfunction

  // Toy execute unit: what the downstream stage would compute for a slot.
  function automatic res_t exec(input slot_t s);
    res_t r;
    r = '0;
    case (s.instr[6:0])
      7'b0010011: begin r.we = 1'b1; r.rd = s.a + {{52{s.instr[31]}}, s.instr[31:20]}; end
      7'b0110011: begin r.we = 1'b1; r.rd = s.a + s.b; end
      7'b1110011: begin
        if (s.instr == MRET) r.csrd = s.c ^ 64'h88;
        else if (s.instr[14:12] != 3'b000) begin
          r.we   = 1'b1;
          r.rd   = s.c;
          r.csrd = s.instr[14] ? {59'd0, s.instr[19:15]} : s.a;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic apply(input slot_t s);
    res_t        r;
    logic [11:0] t;
    r = exec(s);
    t = tgt(s.instr);
    if (r.we && s.instr[11:7] != 5'd0) arch[s.instr[11:7]] = r.rd;
    if (s.instr == MRET) csr_m[t] = r.csrd;
    else if (s.instr[6:0] == 7'b1110011 && impl(t)) begin
      case (s.instr[13:12])
        2'b01: csr_m[t] = r.csrd;
        2'b10: if (s.instr[19:15] != 5'd0) csr_m[t] = csr_m[t] | r.csrd;
        2'b11: if (s.instr[19:15] != 5'd0) csr_m[t] = csr_m[t] & ~r.csrd;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) arch[i] = '0;
    for (int i = 0; i < 4096; i++) csr_m[i] = '0;
    ex_s = '0; wb_v = 1'b0; wb_i = '0; wb_r = '0;
  endtask

  task automatic cycle(input logic ifv, input logic [31:0] ins, input logic flash,
                       input logic use_model);
    slot_t cap;
    res_t  er;
    er = exec(ex_s);
    IF_VALID = ifv; IF_INSTR = ins; IF_PC = pc_ctr; FLASH = flash;
    EX_VALID = ex_s.v; EX_WE = er.we; FWD_RD = er.rd; FWD_CSRD = er.csrd;
    WB_VALID = wb_v; WB_INSTR = wb_i; WB_WE = wb_r.we; WB_RD = wb_r.rd; WB_CSRD = wb_r.csrd;
    cap.v = ifv && !flash; cap.instr = ins; cap.pc = pc_ctr;
    cap.a = gpr(ins[19:15]); cap.b = gpr(ins[24:20]); cap.c = csrr(tgt(ins));
    @(posedge CLK);
    wb_v = ex_s.v; wb_i = ex_s.instr; wb_r = er;
    if (ifv) begin
      ex_s = cap;
      if (cap.v) apply(cap);
    end else ex_s.v = 1'b0;
    pc_ctr += 4;
    #1;
    if (use_model) begin
      chk("OVALID", 64'(OVALID), 64'(ex_s.v));
      if (ex_s.v) begin
        chk("OPC", OPC, ex_s.pc);
        chk("OINSTR", 64'(OINSTR), 64'(ex_s.instr));
        chk("ORS1", ORS1, ex_s.a);
        chk("ORS2", ORS2, ex_s.b);
        chk("OCSR", OCSR, ex_s.c);
      end
    end
  endtask

  function automatic logic [31:0] gen();
    int          k, rd, r1, r2;
    logic [11:0] c;
    k  = $urandom_range(0, 9);
    rd = $urandom_range(0, 7); r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7);
    case ($urandom_range(0, 6))
      0: c = 12'h300; 1: c = 12'h305; 2: c = 12'h340; 3: c = 12'h341;
      4: c = 12'h342; 5: c = 12'h343; default: c = 12'h7C0;
    endcase
    case (k)
      0, 1, 2, 3: return addi(rd, r1, int'($urandom_range(0, 4095)));
      4, 5:       return addr(rd, r1, r2);
      6:          return {7'($urandom), 5'(r2), 5'(r1), 3'b011, 5'(rd), 7'b0100011};
      7, 8: begin
        case ($urandom_range(0, 5))
          0: return csri(1, rd, r1, int'(c)); 1: return csri(2, rd, r1, int'(c));
          2: return csri(3, rd, r1, int'(c)); 3: return csri(5, rd, r1, int'(c));
          4: return csri(6, rd, r1, int'(c)); default: return csri(7, rd, r1, int'(c));
        endcase
      end
      default:    return MRET;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " OVALID"}, 64'(OVALID), 64'd0);
    chk({tag, " OPC"}, OPC, 64'd0);
    chk({tag, " OINSTR"}, 64'(OINSTR), 64'h13);
    chk({tag, " ORS1"}, ORS1, 64'd0);
    chk({tag, " ORS2"}, ORS2, 64'd0);
    chk({tag, " OCSR"}, OCSR, 64'd0);
    chk({tag, " IF_READY"}, 64'(IF_READY), 64'd0);
  endtask

  initial begin
    // {instr, flash, exp_valid, exp_rs1, exp_rs2, exp_csr}
    tbl[0]  = '{addi(5, 0, 7),           1'b0, 1'b1, 64'h0,  64'h0,  64'h0};
    tbl[1]  = '{addi(6, 5, 1),           1'b0, 1'b1, 64'h7,  64'h0,  64'h0};
    tbl[2]  = '{addi(7, 5, 2),           1'b0, 1'b1, 64'h7,  64'h0,  64'h0};
    tbl[3]  = '{addi(8, 5, 3),           1'b0, 1'b1, 64'h7,  64'h0,  64'h0};
    tbl[4]  = '{addi(0, 0, 5),           1'b0, 1'b1, 64'h0,  64'h7,  64'h0};
    tbl[5]  = '{addi(9, 0, 0),           1'b0, 1'b1, 64'h0,  64'h0,  64'h0};
    tbl[6]  = '{addi(10, 0, 0),          1'b0, 1'b1, 64'h0,  64'h0,  64'h0};
    tbl[7]  = '{addi(11, 0, 0),          1'b0, 1'b1, 64'h0,  64'h0,  64'h0};
    tbl[8]  = '{addi(2, 0, 'hA5),        1'b0, 1'b1, 64'h0,  64'h7,  64'h0};
    tbl[9]  = '{addi(4, 0, 'h5A),        1'b0, 1'b1, 64'h0,  64'h0,  64'h0};
    tbl[10] = '{csri(1, 1, 2, 'h340),    1'b0, 1'b1, 64'hA5, 64'h0,  64'h0};
    tbl[11] = '{csri(2, 3, 4, 'h340),    1'b0, 1'b1, 64'h5A, 64'h0,  64'hA5};
    tbl[12] = '{csri(2, 12, 0, 'h340),   1'b0, 1'b1, 64'h0,  64'h0,  64'hFF};
    tbl[13] = '{csri(2, 13, 0, 'h340),   1'b0, 1'b1, 64'h0,  64'h0,  64'hFF};
    tbl[14] = '{csri(2, 14, 0, 'h340),   1'b0, 1'b1, 64'h0,  64'h0,  64'hFF};
    tbl[15] = '{addi(15, 1, 0),          1'b1, 1'b0, 64'h0,  64'h0,  64'h0};
    tbl[16] = '{addi(17, 0, 1),          1'b1, 1'b0, 64'h0,  64'h0,  64'h0};
    tbl[17] = '{addr(16, 13, 3),         1'b0, 1'b1, 64'hFF, 64'hA5, 64'h0};
    tbl[18] = '{addr(18, 1, 12),         1'b0, 1'b1, 64'h0,  64'hFF, 64'h0};

    model_reset();
    @(posedge CLK); #1;
    chk_reset_outputs("reset");
    RSTn = 1'b1;
    #1 chk("IF_READY after release", 64'(IF_READY), 64'd1);

    for (int i = 0; i < 16; i++) cycle(1'b1, addr(0, 2 * i, 2 * i + 1), 1'b0, 1'b1);

    for (int i = 0; i < 19; i++) begin
      cycle(1'b1, tbl[i].instr, tbl[i].flash, 1'b0);
      chk($sformatf("T%0d OVALID", i), 64'(OVALID), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("T%0d OINSTR", i), 64'(OINSTR), 64'(tbl[i].instr));
        chk($sformatf("T%0d ORS1", i), ORS1, tbl[i].e1);
        chk($sformatf("T%0d ORS2", i), ORS2, tbl[i].e2);
        chk($sformatf("T%0d OCSR", i), OCSR, tbl[i].ec);
      end
    end

    // Asynchronous reset while x20's write is still in execute.
    cycle(1'b1, addi(20, 0, 'h33), 1'b0, 1'b1);
    #2 RSTn = 1'b0;
    IF_VALID = 1'b0; EX_VALID = 1'b0; WB_VALID = 1'b0; FLASH = 1'b0;
    #1 chk_reset_outputs("midreset");
    model_reset();
    @(posedge CLK); #1 RSTn = 1'b1;
    cycle(1'b0, 32'h13, 1'b0, 1'b1);
    cycle(1'b0, 32'h13, 1'b0, 1'b1);
    cycle(1'b1, addi(21, 20, 0), 1'b0, 1'b1);
    chk("x20 after reset", ORS1, 64'd0);
    cycle(1'b1, csri(2, 0, 0, 'h340), 1'b0, 1'b1);
    chk("mscratch after reset", OCSR, 64'd0);

    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 99) < 85, gen(), $urandom_range(0, 99) < 10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
